// File: rtl/xgriscv_regdump.sv
// Register-file dump engine: on a PC match, streams pc, instr and x0..x(NREGS-1) over valid/ready.
// Optional feature macro: REGDUMP_CHECKSUM_EN appends an XOR checksum word after the last register.
module xgriscv_regdump #(
    parameter logic [31:0] DUMP_PC = 32'h0000_0048,
    parameter int          NREGS   = 32,
    parameter int          TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_idx,
    output logic        out_last,
    output logic        done,
    output logic        timeout
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [4:0]    LAST_REG = 5'(NREGS - 1);
    localparam logic [CW-1:0] CNT_TRIP = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_HDR_PC, S_HDR_INSTR, S_SEL, S_SEND, S_DONE, S_CSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_HDR_PC, S_HDR_INSTR, S_SEL, S_SEND, S_DONE
    } state_t;
`endif

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          timeout_reg, timeout_next;
    logic [31:0]   pc_lat_reg, pc_lat_next;
    logic [31:0]   instr_lat_reg, instr_lat_next;
    logic [4:0]    idx_reg, idx_next;
    logic [4:0]    reg_sel_reg, reg_sel_next;
    logic [31:0]   data_reg, data_next;
`ifdef REGDUMP_CHECKSUM_EN
    logic [31:0]   csum_reg, csum_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            timeout_reg   <= 1'b0;
            pc_lat_reg    <= '0;
            instr_lat_reg <= '0;
            idx_reg       <= '0;
            reg_sel_reg   <= '0;
            data_reg      <= '0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_reg      <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            timeout_reg   <= timeout_next;
            pc_lat_reg    <= pc_lat_next;
            instr_lat_reg <= instr_lat_next;
            idx_reg       <= idx_next;
            reg_sel_reg   <= reg_sel_next;
            data_reg      <= data_next;
`ifdef REGDUMP_CHECKSUM_EN
            csum_reg      <= csum_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        timeout_next   = timeout_reg;
        pc_lat_next    = pc_lat_reg;
        instr_lat_next = instr_lat_reg;
        idx_next       = idx_reg;
        reg_sel_next   = reg_sel_reg;
        data_next      = data_reg;
`ifdef REGDUMP_CHECKSUM_EN
        csum_next      = csum_reg;
`endif
        out_valid      = 1'b0;
        out_data       = '0;
        out_idx        = '0;
        out_last       = 1'b0;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_next   = S_ARMED;
                    cnt_next     = '0;
                    timeout_next = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                    csum_next    = '0;
`endif
                end
            end
            S_ARMED: begin
                // Saturating watchdog; a PC match in the trip cycle still wins.
                if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + 1'b1;
                end
                if (pc == DUMP_PC) begin
                    pc_lat_next    = pc;
                    instr_lat_next = instr;
                    state_next     = S_HDR_PC;
                end else if (cnt_reg == CNT_TRIP) begin
                    timeout_next = 1'b1;
                    state_next   = S_DONE;
                end
            end
            S_HDR_PC: begin
                out_valid = 1'b1;
                out_data  = pc_lat_reg;
                out_idx   = 6'd0;
                if (out_ready) begin
                    state_next = S_HDR_INSTR;
                end
            end
            S_HDR_INSTR: begin
                out_valid = 1'b1;
                out_data  = instr_lat_reg;
                out_idx   = 6'd1;
                if (out_ready) begin
                    idx_next     = '0;
                    reg_sel_next = '0;
                    state_next   = S_SEL;
                end
            end
            S_SEL: begin
                // x0 is architecturally zero whatever the debug port returns.
                data_next  = (reg_sel_reg == 5'd0) ? 32'd0 : reg_data;
                state_next = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_data  = data_reg;
                out_idx   = 6'd2 + {1'b0, idx_reg};
`ifdef REGDUMP_CHECKSUM_EN
                out_last  = 1'b0;
`else
                out_last  = (idx_reg == LAST_REG);
`endif
                if (out_ready) begin
                    if (idx_reg == LAST_REG) begin
`ifdef REGDUMP_CHECKSUM_EN
                        state_next = S_CSUM;
`else
                        state_next = S_DONE;
`endif
                    end else begin
                        idx_next     = idx_reg + 1'b1;
                        reg_sel_next = idx_reg + 1'b1;
                        state_next   = S_SEL;
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM: begin
                out_valid = 1'b1;
                out_data  = csum_reg;
                out_idx   = 6'(NREGS + 2);
                out_last  = 1'b1;
                if (out_ready) begin
                    state_next = S_DONE;
                end
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase

`ifdef REGDUMP_CHECKSUM_EN
        if (out_valid && out_ready) begin
            csum_next = csum_reg ^ out_data;
        end
`endif
    end

    assign reg_sel = reg_sel_reg;
    assign done    = (state_reg == S_DONE);
    assign timeout = timeout_reg;

endmodule

// File: doc/xgriscv_regdump.md
# xgriscv_regdump

Hardware register-file dump engine for the xgriscv CPU. Watches the committed PC and, when it reaches a configured halt address, sequentially reads all architectural registers through the core's `reg_sel`/`reg_data` debug port. It streams PC, instruction and register contents out as 32-bit words over a valid/ready interface. A watchdog counter ends an armed session that never reaches the halt address. It sits beside `xgriscv_sc`, and its stream feeds a UART or trace sink on the FPGA build.

## Interface
- `DUMP_PC`, 32'h00000048: PC value that triggers the dump.
- `NREGS`, 32: registers dumped, indices 0..NREGS-1 (max 32).
- `TIMEOUT`, 1000: armed cycles before the session aborts.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `arm` in 1: one-cycle pulse that starts a session (from IDLE or DONE only).
- `pc` in 32: current PC of the core.
- `instr` in 32: instruction at `pc`.
- `reg_sel` out 5: register index driven into the core debug port.
- `reg_data` in 32: register value, combinational from `reg_sel`.
- `out_valid` out 1: stream word valid.
- `out_ready` in 1: sink accepts the word.
- `out_data` out 32: stream word.
- `out_idx` out 6: index of the current word.
- `out_last` out 1: final word of the dump.
- `done` out 1: session finished (dump complete or timeout).
- `timeout` out 1: the session ended by watchdog.

## Operation
- States: IDLE, ARMED, HDR_PC, HDR_INSTR, SEL, SEND, DONE (plus CSUM when configured).
- IDLE: all outputs are low. `arm` moves the engine to ARMED, clears the cycle counter, `done` and `timeout`.
- ARMED: the counter increments every cycle.
  - `pc == DUMP_PC`: latch `pc` and `instr`, then go to HDR_PC.
  - Otherwise, counter `== TIMEOUT-1`: go to DONE with `timeout=1`. No words are emitted.
  - A match and the timeout in the same cycle: the match wins.
- HDR_PC: emit word 0 = latched pc.
- HDR_INSTR: emit word 1 = latched instr.
- SEL: drive `reg_sel=i`. At the end of the cycle, capture `reg_data` (force 0 when i==0), then go to SEND.
- SEND: emit word 2+i. On handshake, if i==NREGS-1 go to DONE (or CSUM), else i+1 and return to SEL.
- DONE: `done=1` and `timeout` hold until `arm` or `rst`. `arm` in DONE behaves as in IDLE.
- `arm` in any other state is ignored.
- Stream rules:
  - `out_data`, `out_idx` and `out_last` are stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a handshake.
  - `out_last` is high only on the final word.
- `reg_sel` holds its last value outside SEL and resets to 0.
- `pc`/`instr` changes after the latch do not affect the header words.
- Counter width is `$clog2(TIMEOUT+1)`. It saturates and never wraps.

## Timing
- Reset values: `reg_sel=0`, `out_valid=0`, `out_data=0`, `out_idx=0`, `out_last=0`, `done=0`, `timeout=0`; state IDLE.
- `rst` mid-dump: next edge returns to IDLE and `out_valid` is 0. The partial dump is discarded.
- PC match in cycle N: `out_valid` for word 0 in cycle N+1.
- Header words: one cycle each with `out_ready` held high.
- Register words: two cycles each (SEL plus SEND) with `out_ready` held high.
- Full dump with `out_ready` held high: 2 + 2·NREGS cycles from first valid to last handshake; 66 for NREGS=32.
- `done` rises the cycle after the `out_last` handshake, or the cycle after the timeout decision.
- `reg_data` must be valid within the SEL cycle; the core's register file read is combinational.

## Configuration
- `REGDUMP_CHECKSUM_EN` defined: after the last register word, state CSUM emits one extra word. Its index is 2+NREGS and its value is the XOR of all preceding words. `out_last` moves to this word, and the dump is 35 words for NREGS=32.
- `REGDUMP_CHECKSUM_EN` undefined: there is no CSUM state, and `out_last` is on register NREGS-1.

## Test plan
- Trigger: reset, `arm`, `out_ready=1`, `pc` reaches 0x48 with `instr=0x00000013` and x7 = 0x0000000C → words 0x48, 0x13, rf0=0 … rf7=0x0C …; `out_last` on idx 33; `done` at +1 cycle; `timeout=0`.
- Timeout: `arm`, `pc` never equals 0x48 → `done=1` and `timeout=1` after 1000 armed cycles; `out_valid` never asserted.
- Backpressure: hold `out_ready` low for 5 cycles on idx 9 → `out_data`/`out_idx` are unchanged across the stall and no word is lost or duplicated; 34 handshakes total.
- x0 forcing: the core drives `reg_data=0xDEADBEEF` for `reg_sel=0` → word 2 is 0x00000000.
- Reset and re-arm: assert `rst` at idx 20, then re-arm → outputs return to reset values the next cycle and a complete 34-word dump follows.
- With `REGDUMP_CHECKSUM_EN`: idx 34 equals the XOR of words 0..33, and `out_last` is only on idx 34.
